// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// A shift-add multiply or restoring divide takes WIDTH steps, plus one cycle of sign fix-up.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; accepts MULT/DIV (-> RUN) or MTHI/MTLO (write, stay)
// RUN   | one multiply/divide step per cycle, counter counts down
// FIX   | sign correction, HI/LO write unless flushed
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             AnyStall,
   input  logic [2:0]       Op_ME,
   input  logic             ReadHiLo_ME,
   input  logic [WIDTH-1:0] A_ME,
   input  logic [WIDTH-1:0] B_ME,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Stall_EX
);

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               div0;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   sh;

   logic               op_valid;
   logic               accept;
   logic               accept_long;
   logic               signed_op;
   logic               div_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign op_valid    = (Op_ME != OP_NOP) && (Op_ME != OP_RSVD);
   assign accept      = (state == S_IDLE) && op_valid && !AnyStall && !flush;
   assign accept_long = accept && (Op_ME != OP_MTHI) && (Op_ME != OP_MTLO);
   assign signed_op   = (Op_ME == OP_MULT) || (Op_ME == OP_DIV);
   assign div_op      = (Op_ME == OP_DIV) || (Op_ME == OP_DIVU);
   assign a_neg       = signed_op && A_ME[WIDTH-1];
   assign b_neg       = signed_op && B_ME[WIDTH-1];
   assign a_mag       = a_neg ? (WIDTH'(0) - A_ME) : A_ME;
   assign b_abs       = b_neg ? (WIDTH'(0) - B_ME) : B_ME;

   assign Busy     = (state != S_IDLE);
   assign Stall_EX = Busy && (ReadHiLo_ME || op_valid);

   // Multiply keeps the partial product in {acc, sh} with the multiplier shifting out of sh;
   // divide keeps the partial remainder in acc and shifts the dividend out of / quotient into sh.
   assign mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
   assign div_trial = {acc, sh[WIDTH-1]};
   assign div_diff  = div_trial - {1'b0, b_mag};

   assign prod     = {acc, sh};
   assign prod_fix = neg_q ? ((2*WIDTH)'(0) - prod) : prod;
   assign quo_fix  = neg_q ? (WIDTH'(0) - sh) : sh;
   assign rem_fix  = neg_r ? (WIDTH'(0) - acc) : acc;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (accept_long) state_next = S_RUN;
         S_RUN: begin
            if (flush)                  state_next = S_IDLE;
            else if (cnt == CNT_W'(1))  state_next = S_FIX;
         end
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Hi     <= '0;
         Lo     <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         a_raw  <= '0;
         b_mag  <= '0;
         acc    <= '0;
         sh     <= '0;
      end else begin
         if (accept && (Op_ME == OP_MTHI)) Hi <= A_ME;
         if (accept && (Op_ME == OP_MTLO)) Lo <= A_ME;

         if (accept_long) begin
            cnt    <= CNT_W'(WIDTH);
            is_div <= div_op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= div_op && (B_ME == '0);
            a_raw  <= A_ME;
            acc    <= '0;
            b_mag  <= div_op ? b_abs : a_mag;
            sh     <= div_op ? a_mag : b_abs;
         end

         if (state == S_RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) begin
               if (!div_diff[WIDTH]) begin
                  acc <= div_diff[WIDTH-1:0];
                  sh  <= {sh[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= div_trial[WIDTH-1:0];
                  sh  <= {sh[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc <= mul_sum[WIDTH:1];
               sh  <= {mul_sum[0], sh[WIDTH-1:1]};
            end
         end

         if ((state == S_FIX) && !flush) begin
            if (!is_div) begin
               Hi <= prod_fix[2*WIDTH-1:WIDTH];
               Lo <= prod_fix[WIDTH-1:0];
            end else if (div0) begin
               Hi <= a_raw;
               Lo <= '1;
            end else begin
               Hi <= rem_fix;
               Lo <= quo_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit and an 8-bit instance share the control inputs.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, flush, any_stall, rd;
   logic [2:0]  op;
   logic [31:0] a32, b32, hi32, lo32;
   logic [7:0]  a8, b8, hi8, lo8;
   logic        busy32, stall32, busy8, stall8;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .flush(flush), .AnyStall(any_stall), .Op_ME(op),
      .ReadHiLo_ME(rd), .A_ME(a32), .B_ME(b32), .Hi(hi32), .Lo(lo32),
      .Busy(busy32), .Stall_EX(stall32));

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .flush(flush), .AnyStall(any_stall), .Op_ME(op),
      .ReadHiLo_ME(rd), .A_ME(a8), .B_ME(b8), .Hi(hi8), .Lo(lo8),
      .Busy(busy8), .Stall_EX(stall8));

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      op = o; a32 = a; b32 = b; a8 = a[7:0]; b8 = b[7:0];
      @(posedge clk); #1;
      op = 3'b000;
   endtask

   task automatic wait_busy32(output int n);
      n = 0;
      @(negedge clk);
      while (busy32 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_busy8(output int n);
      n = 0;
      @(negedge clk);
      while (busy8 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int n;
      issue(o, a, b);
      wait_busy32(n);
      check_val({tag, "_cycles"}, 64'(n), 64'd33);
      check_val({tag, "_hi"}, 64'(hi32), 64'(eh));
      check_val({tag, "_lo"}, 64'(lo32), 64'(el));
   endtask

   task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] e);
      int n;
      issue(o, {24'h0, a}, {24'h0, b});
      wait_busy8(n);
      check_val({tag, "_cycles"}, 64'(n), 64'd9);
      check_val({tag, "_hilo"}, 64'({hi8, lo8}), 64'(e));
   endtask

   // Reference result {hi, lo} for the 8-bit instance
   function automatic logic [15:0] ref8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      int sa, sb, ua, ub, p, q, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      case (o)
         3'b001: begin p = sa * sb; return p[15:0]; end
         3'b010: begin p = ua * ub; return p[15:0]; end
         3'b011: begin
            if (b == 8'h00) return {a, 8'hFF};
            if (sa == -128 && sb == -1) return 16'h0080;
            q = sa / sb;
            r = sa % sb;
            return {r[7:0], q[7:0]};
         end
         default: begin
            if (b == 8'h00) return {a, 8'hFF};
            q = ua / ub;
            r = ua % ub;
            return {r[7:0], q[7:0]};
         end
      endcase
   endfunction

   initial begin
      int n;
      logic [2:0] ro;
      logic [7:0] ra, rb;

      reset = 1'b1; flush = 1'b0; any_stall = 1'b0; rd = 1'b0; op = 3'b000;
      a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_val("rst_hi", 64'(hi32), 64'h0);
      check_val("rst_lo", 64'(lo32), 64'h0);
      check_val("rst_busy", 64'(busy32), 64'h0);
      check_val("rst_stall", 64'(stall32), 64'h0);

      run32("multu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run32("mult_neg", 3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run32("div_neg", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run32("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run32("divu_zero", 3'b100, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
      run32("div_zero_s", 3'b011, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

      // Dependent read arrives one cycle into the divide and must stall until Busy drops
      issue(3'b100, 32'd100, 32'd7);
      @(posedge clk); #1 rd = 1'b1;
      n = 0;
      @(negedge clk);
      while (busy32 && n < 200) begin
         if (stall32) n++;
         @(negedge clk);
      end
      check_val("stall_cycles", 64'(n), 64'd32);
      check_val("stall_released", 64'(stall32), 64'h0);
      check_val("stall_lo", 64'(lo32), 64'd14);
      check_val("stall_hi", 64'(hi32), 64'd2);
      #1 rd = 1'b0;

      issue(3'b101, 32'h1234_5678, 32'h0);
      @(negedge clk);
      check_val("mthi_hi", 64'(hi32), 64'h1234_5678);
      check_val("mthi_busy", 64'(busy32), 64'h0);

      issue(3'b010, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check_val("flush_busy", 64'(busy32), 64'h0);
      check_val("flush_hi", 64'(hi32), 64'h1234_5678);
      check_val("flush_lo", 64'(lo32), 64'd14);
      run32("retry", 3'b010, 32'd3, 32'd4, 32'h0, 32'h0000_000C);

      @(posedge clk); #1;
      any_stall = 1'b1; op = 3'b110; a32 = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      any_stall = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; op = 3'b000;
      @(negedge clk);
      check_val("blocked_mtlo", 64'(lo32), 64'h0000_000C);

      for (int i = 0; i < 10; i++) begin
         ro = 3'(1 + $urandom_range(0, 3));
         ra = 8'($urandom_range(0, 255));
         rb = (i == 3) ? 8'h00 : 8'($urandom_range(0, 255));
         run8($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref8(ro, ra, rb));
      end
      run8("w8_mult_mn", 3'b001, 8'h80, 8'h80, 16'h4000);
      run8("w8_div_ovf", 3'b011, 8'h80, 8'hFF, 16'h0080);

      issue(3'b001, 32'h0000_007F, 32'h0000_007F);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_val("midrst_hi8", 64'(hi8), 64'h0);
      check_val("midrst_lo8", 64'(lo8), 64'h0);
      check_val("midrst_busy8", 64'(busy8), 64'h0);
      check_val("midrst_lo32", 64'(lo32), 64'h0);
      check_val("midrst_busy32", 64'(busy32), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
